// File: rtl/key_code_decoder.sv
// ---------------------------------------------------------------------------
// key_code_decoder
//
// Receive-side partner of the keypad's 10-line active-low priority encoder.
// The encoder's active-low code is registered, debounced by a counter-based
// FSM, and the accepted key number is re-expanded to a 10-line active-low
// one-hot bus (74HC42 style).
//
// Parameters
//   DEB_CYCLES  consecutive identical observations needed to accept a press
//               or a release (legal range 1..255)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   y_n[3:0]   in   encoder code, active-low (key k arrives as ~k, 4'hF idle)
//   key[3:0]   out  latched key number 0..9, 0 means no key
//   q_n[9:0]   out  registered active-low one-hot decode of key
//   key_valid  out  high while a debounced key 1..9 is latched
//   key_pulse  out  one-cycle strobe on each accepted new press
//   err        out  sticky flag, set when a code 10..15 is observed
// ---------------------------------------------------------------------------
module key_code_decoder #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] y_n,
    output logic [3:0] key,
    output logic [9:0] q_n,
    output logic       key_valid,
    output logic       key_pulse,
    output logic       err
);

    // Counter width is just enough to hold DEB_CYCLES; counters saturate.
    localparam int               CNT_W      = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEB_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       s_q;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [3:0]       key_q, key_d;
    logic [9:0]       qn_q, qn_d;
    logic             valid_q, valid_d;
    logic             pulse_q, pulse_d;
    logic             err_q, err_d;

    logic             isKey;
    logic             isInvalid;
    logic [CNT_W-1:0] cntInc;
    logic [CNT_W-1:0] rcntInc;

    // Classify the registered code and precompute the saturating increments
    // used by both debounce counters.
    always_comb begin
        isKey     = (s_q != 4'd0) && (s_q <= 4'd9);
        isInvalid = (s_q >= 4'd10);
        cntInc    = (cnt_q  == CNT_MAX) ? cnt_q  : cnt_q  + CNT_W'(1);
        rcntInc   = (rcnt_q == CNT_MAX) ? rcnt_q : rcnt_q + CNT_W'(1);
    end

    // Next-state logic. A commit writes key/valid/pulse on the same edge that
    // the final matching observation is made, so the outputs appear exactly
    // DEB_CYCLES observations after the code first reaches the FSM. Key 0 is
    // indistinguishable from idle at the encoder and is never accepted.
    // Invalid codes behave as "no key" and additionally set the sticky error.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        key_d   = key_q;
        valid_d = valid_q;
        pulse_d = 1'b0;
        err_d   = err_q | isInvalid;

        case (state_q)
            IDLE: begin
                if (isKey) begin
                    cand_d = s_q;
                    if (DEB_CYCLES == 1) begin
                        key_d   = s_q;
                        valid_d = 1'b1;
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                        rcnt_d  = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = DEBOUNCE;
                    end
                end
            end

            DEBOUNCE: begin
                if (isKey && (s_q == cand_q)) begin
                    cnt_d = cntInc;
                    if (cntInc >= DEB_TARGET) begin
                        key_d   = cand_q;
                        valid_d = 1'b1;
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                        rcnt_d  = '0;
                        state_d = HELD;
                    end
                end else if (isKey) begin
                    // A different key restarts the debounce on the new key.
                    cand_d = s_q;
                    cnt_d  = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            HELD: begin
                // Anything other than the held key, including another valid
                // key, counts toward release; the new key is only considered
                // once the old one has been released.
                if (s_q == key_q) begin
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcntInc;
                    if (rcntInc >= DEB_TARGET) begin
                        key_d   = 4'd0;
                        valid_d = 1'b0;
                        rcnt_d  = '0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        qn_d = ~(10'b1 << key_d);
    end

    // State and output registers. The input code is inverted into s_q every
    // cycle so the FSM always observes the previous cycle's encoder value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 4'd0;
            cand_q  <= 4'd0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            key_q   <= 4'd0;
            qn_q    <= 10'h3FE;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= ~y_n;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            key_q   <= key_d;
            qn_q    <= qn_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
        end
    end

    assign key       = key_q;
    assign q_n       = qn_q;
    assign key_valid = valid_q;
    assign key_pulse = pulse_q;
    assign err       = err_q;

endmodule

// File: tb/tb_key_code_decoder.sv
// ---------------------------------------------------------------------------
// tb_key_code_decoder
//
// Directed bench for key_code_decoder with DEB_CYCLES = 4. Stimulus tasks
// schedule the expected output snapshots (edge number plus all outputs) into
// a queue; an independent monitor on the falling edge compares whenever the
// outputs change, a press strobe is seen, or a scheduled snapshot falls due.
// ---------------------------------------------------------------------------
module tb_key_code_decoder;

    logic       clk;
    logic       rst;
    logic [3:0] y_n;
    logic [3:0] key;
    logic [9:0] q_n;
    logic       key_valid;
    logic       key_pulse;
    logic       err;

    typedef struct {
        int         edgeNum;
        logic [3:0] key;
        logic [9:0] qn;
        logic       valid;
        logic       pulse;
        logic       err;
    } expect_t;

    expect_t     expQ[$];
    int          cycleNum    = 0;
    int          assertCount = 0;
    int          failCount   = 0;
    bit          monOn       = 1'b0;
    logic [16:0] lastSnap;

    key_code_decoder #(
        .DEB_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .y_n      (y_n),
        .key      (key),
        .q_n      (q_n),
        .key_valid(key_valid),
        .key_pulse(key_pulse),
        .err      (err)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter, so expectations can name the exact rising edge.
    always @(posedge clk) cycleNum <= cycleNum + 1;

    // Queue an expected snapshot, kept in edge order.
    task automatic pushExpect(input int e, input logic [3:0] k, input logic [9:0] qn,
                              input logic v, input logic p, input logic er);
        expect_t x;
        int      idx;
        x.edgeNum = e;
        x.key     = k;
        x.qn      = qn;
        x.valid   = v;
        x.pulse   = p;
        x.err     = er;
        idx       = expQ.size();
        for (int i = 0; i < expQ.size(); i++) begin
            if (expQ[i].edgeNum > e) begin
                idx = i;
                break;
            end
        end
        expQ.insert(idx, x);
    endtask

    // Expect the given steady outputs at the current cycle.
    task automatic checkOutput(input logic [3:0] k, input logic [9:0] qn,
                               input logic v, input logic er);
        pushExpect(cycleNum, k, qn, v, 1'b0, er);
    endtask

    // Drive y_n just after a rising edge and hold it for a number of edges.
    task automatic applyStimulus(input logic [3:0] yn, input int cycles);
        y_n = yn;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [9:0] act, input logic [9:0] exp, input int e);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, e, act, exp);
        end
    endtask

    // Monitor: sample away from the active edge and consume the scoreboard.
    always @(negedge clk) begin
        logic [16:0] snap;
        bit          evt;
        expect_t     x;
        if (monOn) begin
            snap = {key, q_n, key_valid, key_pulse, err};
            evt  = (snap !== lastSnap) || (key_pulse === 1'b1);
            while (expQ.size() > 0 && expQ[0].edgeNum < cycleNum) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL missed_check for edge %0d: got no sample, expected key=%0d valid=%b pulse=%b",
                         expQ[0].edgeNum, expQ[0].key, expQ[0].valid, expQ[0].pulse);
                void'(expQ.pop_front());
            end
            if (expQ.size() > 0 && expQ[0].edgeNum == cycleNum) begin
                x = expQ.pop_front();
                cmp("key",       10'(key),       10'(x.key),   cycleNum);
                cmp("q_n",       q_n,            x.qn,         cycleNum);
                cmp("key_valid", 10'(key_valid), 10'(x.valid), cycleNum);
                cmp("key_pulse", 10'(key_pulse), 10'(x.pulse), cycleNum);
                cmp("err",       10'(err),       10'(x.err),   cycleNum);
            end else if (evt) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_output at edge %0d: got key=%0d q_n=%h valid=%b pulse=%b err=%b, expected no change",
                         cycleNum, key, q_n, key_valid, key_pulse, err);
            end
            lastSnap = snap;
        end
    end

    initial begin
        int c0;

        // Reset with a random encoder code present.
        rst = 1'b1;
        y_n = 4'($urandom);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        y_n      = 4'hF;
        lastSnap = {4'd0, 10'h3FE, 1'b0, 1'b0, 1'b0};
        monOn    = 1'b1;
        $display("[TB] reset check");
        checkOutput(4'd0, 10'h3FE, 1'b0, 1'b0);
        applyStimulus(4'hF, 3);

        // Clean press and release of key 5.
        $display("[TB] clean press/release key 5");
        c0 = cycleNum;
        pushExpect(c0 + 5, 4'd5, 10'h3DF, 1'b1, 1'b1, 1'b0);
        pushExpect(c0 + 6, 4'd5, 10'h3DF, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1010, 10);
        checkOutput(4'd5, 10'h3DF, 1'b1, 1'b0);
        c0 = cycleNum;
        pushExpect(c0 + 5, 4'd0, 10'h3FE, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'hF, 8);
        checkOutput(4'd0, 10'h3FE, 1'b0, 1'b0);

        // Bouncing key 7 is absorbed, then a solid hold is accepted once.
        $display("[TB] bounce key 7");
        repeat (3) begin
            applyStimulus(4'b1000, 2);
            applyStimulus(4'hF, 2);
        end
        checkOutput(4'd0, 10'h3FE, 1'b0, 1'b0);
        c0 = cycleNum;
        pushExpect(c0 + 5, 4'd7, 10'h37F, 1'b1, 1'b1, 1'b0);
        pushExpect(c0 + 6, 4'd7, 10'h37F, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1000, 10);
        c0 = cycleNum;
        pushExpect(c0 + 5, 4'd0, 10'h3FE, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'hF, 8);

        // Short dropout while key 3 is held must not release or re-pulse.
        $display("[TB] held glitch key 3");
        c0 = cycleNum;
        pushExpect(c0 + 5, 4'd3, 10'h3F7, 1'b1, 1'b1, 1'b0);
        pushExpect(c0 + 6, 4'd3, 10'h3F7, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1100, 8);
        applyStimulus(4'hF, 3);
        applyStimulus(4'b1100, 8);
        checkOutput(4'd3, 10'h3F7, 1'b1, 1'b0);
        c0 = cycleNum;
        pushExpect(c0 + 5, 4'd0, 10'h3FE, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'hF, 8);

        // Direct change from key 2 to key 8: release first, then new press.
        $display("[TB] direct change key 2 -> 8");
        c0 = cycleNum;
        pushExpect(c0 + 5, 4'd2, 10'h3FB, 1'b1, 1'b1, 1'b0);
        pushExpect(c0 + 6, 4'd2, 10'h3FB, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1101, 8);
        c0 = cycleNum;
        pushExpect(c0 + 5,  4'd0, 10'h3FE, 1'b0, 1'b0, 1'b0);
        pushExpect(c0 + 9,  4'd8, 10'h2FF, 1'b1, 1'b1, 1'b0);
        pushExpect(c0 + 10, 4'd8, 10'h2FF, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0111, 12);
        c0 = cycleNum;
        pushExpect(c0 + 5, 4'd0, 10'h3FE, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'hF, 8);

        // One-cycle invalid code sets the sticky error, which survives a
        // later press and release of key 9.
        $display("[TB] invalid code then key 9");
        c0 = cycleNum;
        pushExpect(c0 + 2, 4'd0, 10'h3FE, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0100, 1);
        applyStimulus(4'hF, 4);
        c0 = cycleNum;
        pushExpect(c0 + 5, 4'd9, 10'h1FF, 1'b1, 1'b1, 1'b1);
        pushExpect(c0 + 6, 4'd9, 10'h1FF, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0110, 8);
        c0 = cycleNum;
        pushExpect(c0 + 5, 4'd0, 10'h3FE, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'hF, 8);

        // Reset in the middle of debouncing key 6 (three observations in).
        $display("[TB] reset during debounce");
        c0 = cycleNum;
        applyStimulus(4'b1001, 4);
        rst = 1'b1;
        pushExpect(c0 + 5, 4'd0, 10'h3FE, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'hF, 8);
        checkOutput(4'd0, 10'h3FE, 1'b0, 1'b0);
        applyStimulus(4'hF, 2);

        // Every scheduled snapshot must have been consumed.
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/key_code_decoder.md
# key_code_decoder

Receive-side companion to the 10-line active-low priority encoder in the keypad path. It samples the encoder's active-low 4-bit code and debounces it with a counter-based FSM. It then latches a stable key number and re-expands it to a 10-line active-low one-hot bus, 74HC42-style. The block sits between the encoder output and downstream display/control logic, and provides a one-cycle press event and a sticky error flag.

## Interface
- DEB_CYCLES, default 4: number of consecutive identical FSM observations required to accept a press or a release. Legal range 1..255.
- clk  in  1: single clock, rising edge.
- rst  in  1: synchronous, active-high reset.
- y_n  in  4: encoder code, active-low. Key number k is presented as ~k. 4'b1111 means no key.
- key  out  4: latched key number, binary. 0 means no key.
- q_n  out  10: active-low one-hot decode of `key`. Bit k is low iff key==k. Registered.
- key_valid  out  1: high while a debounced key 1..9 is latched.
- key_pulse  out  1: one-cycle high on each accepted new press.
- err  out  1: sticky. Set when code 10..15 is observed. Cleared only by rst.

## Operation
- Input stage: s <= ~y_n each cycle. Each FSM observation uses s.
- Code classes:
  - s in 1..9 is a key.
  - s==0 is no key. Key 0 is indistinguishable from idle at the encoder, so it is never a key.
  - s in 10..15 is invalid. Invalid codes are treated as no key and set err.
- IDLE:
  - If s is a key: cand<=s, cnt<=1, go DEBOUNCE.
  - If DEB_CYCLES==1, commit directly instead (see commit).
- DEBOUNCE:
  - If s==cand: cnt++. When the observation count reaches DEB_CYCLES, commit.
  - If s is a different key: cand<=s, cnt<=1, stay in DEBOUNCE.
  - If s is no key: go IDLE, cnt<=0.
- Commit (registered on the same edge): key<=cand, key_valid<=1, key_pulse<=1 for exactly that one cycle, go HELD.
- HELD:
  - If s==key: rcnt<=0.
  - Otherwise rcnt++. This includes a different key, which must be released first.
  - When rcnt reaches DEB_CYCLES: key<=0, key_valid<=0, go IDLE, no pulse.
- q_n is always decode(key): q_n = ~(10'b1 << key).
- Width rules: cnt and rcnt are wide enough for DEB_CYCLES and saturate, never wrap. key is 4 bits and holds only 0..9.

## Timing
- Reset values (after the rst edge):
  - key=0, q_n=10'h3FE, key_valid=0, key_pulse=0, err=0.
  - s=0, state IDLE, cnt=rcnt=0.
- rst during DEBOUNCE or HELD aborts the operation; no pulse is issued. rst has priority over all transitions.
- Press latency: y_n changes after edge 0. s captures the code at edge 1. FSM observations occur at edges 2..DEB_CYCLES+1. key, q_n, key_valid and key_pulse update at edge DEB_CYCLES+1 (edge 5 for the default).
- Release latency: symmetric. Outputs clear at edge DEB_CYCLES+1 after y_n returns to 4'b1111.
- Direct key change in HELD (key A to key B): release completes after DEB_CYCLES observations. IDLE then observes B as cnt=1, and B commits at edge 2*DEB_CYCLES+1.
- Glitches shorter than DEB_CYCLES observations are absorbed, in both DEBOUNCE and HELD.
- key_pulse never asserts on two consecutive cycles. At most one pulse is issued per HELD entry.
- err sets on the edge where the FSM observes s in 10..15, in any state. In HELD, that observation also counts toward release.

## Test plan
- Reset: assert rst for 2 cycles with random y_n -> key=0, q_n=10'h3FE, key_valid=0, key_pulse=0, err=0.
- Clean press/release, DEB_CYCLES=4:
  - y_n=4'b1010 (key 5) for 10 cycles -> key_pulse high for one cycle at edge 5; key=5; q_n=10'h3DF; key_valid=1.
  - Then y_n=4'b1111 -> key=0, q_n=10'h3FE, key_valid=0 at edge 5 after the change.
- Bounce: alternate y_n between 4'b1000 (key 7) and 4'b1111 every 2 cycles for 12 cycles -> no pulse, key stays 0. Then hold 4'b1000 -> exactly one pulse, key=7.
- HELD glitch: key 3 held, then y_n=4'b1111 for 3 cycles and back to 4'b1100 -> key stays 3, key_valid stays 1, no second pulse.
- Direct change: key 2 held, y_n switches to 4'b0111 (key 8) -> key=0 at edge 5, then key=8 with a pulse at edge 9.
- Invalid code and mid-operation reset:
  - y_n=4'b0100 (code 11) for 1 cycle -> err=1, held through later key 9 press (q_n=10'h1FF).
  - rst while cnt=3 in DEBOUNCE -> no pulse; all outputs at reset values; err=0.
